ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000, clk cycles PS2_CLK is held low before the start bit (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, maximum clk cycles between consecutive device clock falling edges, and from clock release to the first edge (20 ms).
REQ-003 clk  input  1  system clock, 100 MHz; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 PS2_CLK  inout  1  PS/2 clock line, open-drain: driven 0 or high-Z only.
REQ-006 PS2_DATA  inout  1  PS/2 data line, open-drain: driven 0 or high-Z only.
REQ-007 tx_data  input  8  command byte for the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
REQ-008 tx_valid  input  1  request to send tx_data.
REQ-009 tx_ready  output  1  high only in IDLE; tx_data is accepted on a cycle where tx_valid and tx_ready are both high.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse: frame sent and device ACK received.
REQ-012 err  output  1  one-cycle pulse: frame aborted by timeout or missing ACK.

Function
REQ-013 PS2_CLK and PS2_DATA inputs shall each pass a 2-flop synchronizer; a device clock falling edge (fe) is synchronized clock high on the previous cycle and low on the current cycle.
REQ-014 States: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-015 IDLE: both lines high-Z; on handshake, latch tx_data, compute odd parity (parity = ~^tx_data), clear the edge counter, and go to INHIBIT.
REQ-016 INHIBIT: drive PS2_CLK low for exactly INHIBIT_CYCLES cycles, with PS2_DATA low for the final 1 cycle or more (the start bit); then go to REQ.
REQ-017 REQ: release PS2_CLK, keep PS2_DATA low, start the timeout counter; on the first fe go to SHIFT with bit index 0.
REQ-018 SHIFT: on entry, and on each later fe, present the next bit, LSB first: data bits 0-7, then parity; the bit is presented by driving PS2_DATA low for 0 and high-Z for 1.
REQ-019 SHIFT: on the fe following the parity bit, release PS2_DATA (stop bit) and go to ACK.
REQ-020 ACK: on the next fe, sample synchronized PS2_DATA. If 0, go to WAIT_IDLE. If 1, pulse err and go to IDLE.
REQ-021 WAIT_IDLE: when synchronized PS2_CLK and PS2_DATA are both high, pulse done and go to IDLE.
REQ-022 The timeout counter shall reset on every fe and on every state change. In REQ, SHIFT, ACK and WAIT_IDLE, reaching TIMEOUT_CYCLES shall release both lines, pulse err for one cycle, and return to IDLE.
REQ-023 tx_valid while busy shall be ignored; the byte is not queued.
REQ-024 done and err shall never be high in the same cycle, and exactly one of them shall pulse per accepted byte.
REQ-025 The latched byte shall not change while busy, regardless of tx_data.
REQ-026 Counter widths shall hold TIMEOUT_CYCLES without wrap; counters saturate rather than wrap.

Reset
REQ-027 On rst, in any state including mid-frame:
- state = IDLE
- both lines high-Z
- tx_ready = 1, busy = 0, done = 0, err = 0
- all counters and the shift register cleared
REQ-028 After rst deasserts, the first accepted byte shall begin from INHIBIT with no residue from the aborted frame.

Verification
REQ-029 Send 0xED with a device model that ACKs:
- PS2_CLK held low exactly 10000 cycles
- frame bits observed 0,1,0,1,1,0,1,1,1 (start, LSB-first data, parity 1)
- stop bit = 1
- done pulses once, err stays 0
REQ-030 Send 0xFF:
- parity bit = 1 (eight ones, so odd parity sets it)
- ACK received, then done
REQ-031 Device model withholds ACK (data high at the 11th fe): err pulses once, done = 0, state returns to IDLE, tx_ready = 1.
REQ-032 Device never clocks after release: err at exactly TIMEOUT_CYCLES after entering REQ; both lines high-Z.
REQ-033 Assert rst at the 5th fe of a frame: lines released within 1 cycle, outputs at reset values; then a fresh 0x00 transfer completes with done.
REQ-034 Pulse tx_valid with 0x12 while busy sending 0xF4: only 0xF4 appears on the wire, and exactly one done occurs.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues the start bit, shifts
// out one command byte plus odd parity on device clock edges, and checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DATA,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                         : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);
    localparam int unsigned BIT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [8:0]         shreg_q, shreg_d;
    logic               clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d, clk_prev_q, clk_prev_d;
    logic               data_meta_q, data_meta_d, data_sync_q, data_sync_d;
    logic               clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic               tx_ready_q, tx_ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic               fe_c, timeout_c;
    logic [CNT_W-1:0]   cnt_inc_c;

    // Open-drain pads: only ever pull low or float.
    assign PS2_CLK  = clk_oe_q  ? 1'b0 : 1'bz;
    assign PS2_DATA = data_oe_q ? 1'b0 : 1'bz;

    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

    assign fe_c      = clk_prev_q & ~clk_sync_q;
    assign timeout_c = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
    assign cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_inc_c;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        clk_meta_d  = PS2_CLK;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        data_meta_d = PS2_DATA;
        data_sync_d = data_meta_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (tx_valid) begin
                    state_d = S_INHIBIT;
                    shreg_d = {~^tx_data, tx_data};
                    bit_d   = '0;
                end
            end
            S_INHIBIT: begin
                if (cnt_q >= CNT_W'(INHIBIT_CYCLES - 1)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (fe_c) begin
                    state_d = S_SHIFT;
                    bit_d   = '0;
                end else if (timeout_c) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_SHIFT: begin
                // Bit 8 is parity; the edge after it releases data for the stop bit.
                if (fe_c) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(8)) begin
                        state_d = S_ACK;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shreg_d = {1'b0, shreg_q[8:1]};
                    end
                end else if (timeout_c) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_ACK: begin
                if (fe_c) begin
                    cnt_d = '0;
                    if (!data_sync_q) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end else if (timeout_c) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_sync_q && data_sync_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (timeout_c) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Line drives follow the next state so they are registered alongside it.
        clk_oe_d  = (state_d == S_INHIBIT);
        data_oe_d = 1'b0;
        if (state_d == S_INHIBIT) begin
            data_oe_d = (cnt_d >= CNT_W'(INHIBIT_CYCLES - 1));
        end else if (state_d == S_REQ) begin
            data_oe_d = 1'b1;
        end else if (state_d == S_SHIFT) begin
            data_oe_d = ~shreg_d[0];
        end
        tx_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host and
// compares them with an expected frame built from the byte, plus reset and timeout cases.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 200;
    localparam int unsigned TO   = 1500;
    localparam int unsigned HALF = 20;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, done, err;
    logic       dev_clk_low, dev_data_low;
    wire        ps2_clk, ps2_data;
    int         cyc, done_cnt, err_cnt;
    int         n_chk, n_fail;

    pullup (ps2_clk);
    pullup (ps2_data);
    assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pulse bookkeeping and mutual exclusion of done/err.
    initial begin
        done_cnt = 0;
        err_cnt  = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 || err === 1'b1) begin
                chk("done_err_excl", 32'(done & err), 32'd0);
                if (done === 1'b1) done_cnt++;
                if (err === 1'b1) err_cnt++;
            end
        end
    end

    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones  = 0;
        f     = '0;
        f[0]  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones   = ones + int'(b[i]);
        end
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Measures the clock-low inhibit window; returns at the first sample with the clock released.
    task automatic wait_inhibit(input string tag, output int low_len, output bit ok);
        int guard;
        logic last_data;
        low_len   = 0;
        ok        = 1'b0;
        last_data = 1'b1;
        guard     = 0;
        while (ps2_clk === 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (ps2_clk !== 1'b0) begin
            chk({tag, "_inhibit_start"}, 32'd0, 32'd1);
            return;
        end
        guard = 0;
        while (ps2_clk === 1'b0 && guard < int'(INH) + 100) begin
            low_len++;
            last_data = ps2_data;
            @(negedge clk);
            guard++;
        end
        if (ps2_clk !== 1'b1) begin
            chk({tag, "_inhibit_end"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_start_in_inhibit"}, 32'(last_data), 32'd0);
        ok = 1'b1;
    endtask

    task automatic dev_frame(input string tag, input bit ack, output logic [10:0] bits, output int low_len);
        bit ok;
        bits = '1;
        wait_inhibit(tag, low_len, ok);
        if (!ok) return;
        repeat (5) @(negedge clk);
        bits[0] = ps2_data;
        for (int k = 0; k < 11; k++) begin
            dev_clk_low = 1'b1;
            tx_data     = 8'($urandom);
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k < 10) bits[k+1] = ps2_data;
            if (k == 9 && ack) dev_data_low = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        dev_data_low = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic send(input string tag, input logic [7:0] b, input bit ack);
        logic [10:0] got;
        int low_len, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(b);
        dev_frame(tag, ack, got, low_len);
        chk({tag, "_low_len"}, 32'(low_len), 32'(INH));
        chk({tag, "_frame"}, 32'(got), 32'(model_frame(b)));
        chk({tag, "_done_cnt"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
        chk({tag, "_idle"}, {28'd0, tx_ready, busy, ps2_clk, ps2_data}, 32'b1011);
    endtask

    initial begin
        logic [10:0] got;
        int low_len, d0, e0, t_rel, guard;
        bit ok;
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        tx_data = 8'h00;
        tx_valid = 1'b0;
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {28'd0, tx_ready, busy, done, err}, 32'b1000);
        chk("reset_lines", {30'd0, ps2_clk, ps2_data}, 32'b11);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send("ed", 8'hED, 1'b1);
        send("ff", 8'hFF, 1'b1);
        send("noack", 8'h5A, 1'b0);

        // Device never clocks after release.
        start_tx(8'hA3);
        wait_inhibit("tmo", low_len, ok);
        t_rel = cyc;
        guard = 0;
        while (err !== 1'b1 && guard < int'(TO) + 100) begin
            @(negedge clk);
            guard++;
        end
        chk("tmo_latency", 32'(cyc - t_rel), 32'(TO));
        chk("tmo_lines", {30'd0, ps2_clk, ps2_data}, 32'b11);
        @(negedge clk);
        chk("tmo_after", {28'd0, tx_ready, busy, done, err}, 32'b1000);

        // Reset on the 5th device falling edge.
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h00);
        wait_inhibit("rstmid", low_len, ok);
        repeat (5) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (k < 4) begin
                dev_clk_low = 1'b0;
                repeat (HALF) @(negedge clk);
            end
        end
        chk("rstmid_bit_low", 32'(ps2_data), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_data_rel", 32'(ps2_data), 32'd1);
        chk("rstmid_outputs", {28'd0, tx_ready, busy, done, err}, 32'b1000);
        @(negedge clk);
        dev_clk_low = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_clk_rel", 32'(ps2_clk), 32'd1);
        repeat (5) @(negedge clk);
        chk("rstmid_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        send("after_rst", 8'h00, 1'b1);

        // Request while busy must be dropped.
        d0 = done_cnt;
        start_tx(8'hF4);
        fork
            dev_frame("busy", 1'b1, got, low_len);
            begin
                repeat (50) @(negedge clk);
                tx_data  = 8'h12;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        chk("busy_frame", 32'(got), 32'(model_frame(8'hF4)));
        repeat (50) @(negedge clk);
        chk("busy_no_queue", {30'd0, busy, ps2_clk}, 32'b01);
        chk("busy_done_cnt", 32'(done_cnt - d0), 32'd1);

        for (int i = 0; i < 6; i++) begin
            send("rand", 8'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
